// File: rtl/mfp_sevenseg_pkg.sv
// mfp_sevenseg_pkg: shared seven-segment digit code constants and encoder state encoding
package mfp_sevenseg_pkg;
  localparam int DIGIT_W = 6;
  localparam int GLYPH_W = 5;
  localparam logic [GLYPH_W-1:0] CODE_BLANK = 5'd31;
  localparam logic [GLYPH_W-1:0] CODE_DASH = 5'd22;
  localparam logic DP_OFF = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FMT, S_DONE} state_t;
endpackage

// File: rtl/mfp_bcd_add3.sv
// mfp_bcd_add3: double-dabble nibble correction, y = (a >= 5) ? a + 3 : a
//   a : BCD nibble before the shift
//   y : corrected nibble
module mfp_bcd_add3 (
  input  logic [3:0] a,
  output logic [3:0] y
);
  always_comb y = (a >= 4'd5) ? a + 4'd3 : a;
endmodule

// File: rtl/mfp_ahb_sevensegenc.sv
// mfp_ahb_sevensegenc: sequential binary-to-seven-segment digit code encoder (double-dabble)
//   clk, resetn        : clock, async active-low reset
//   start              : conversion request, honoured only when idle
//   value/blank_en/dp_on : operands, captured when start is accepted
//   busy, done         : conversion in flight / one-cycle result strobe
//   overflow           : last value did not fit in NDIGITS decimal digits
//   digits             : NDIGITS 6-bit codes {~dp, glyph}, digit 0 rightmost
module mfp_ahb_sevensegenc
  import mfp_sevenseg_pkg::*;
#(
  parameter int WIDTH = 27,
  parameter int NDIGITS = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [WIDTH-1:0]             value,
  input  logic                         blank_en,
  input  logic [NDIGITS-1:0]           dp_on,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [DIGIT_W*NDIGITS-1:0]   digits
);
  localparam int BW = 4 * NDIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH-1:0] val;
  logic [BW-1:0] bcd, adj;
  logic [CW-1:0] cnt;
  logic ovf, blank_r;
  logic [NDIGITS-1:0] dp_r;
  logic [DIGIT_W*NDIGITS-1:0] fmt;
  for (genvar g = 0; g < NDIGITS; g++) begin : g_add3
    mfp_bcd_add3 u_add3 (.a(bcd[4*g+:4]), .y(adj[4*g+:4]));
  end
  // A digit is a leading zero when it and every nibble above it are zero.
  always_comb begin
    fmt = '0;
    for (int i = 0; i < NDIGITS; i++)
      fmt[DIGIT_W*i+:DIGIT_W] = {dp_r[i] ? ~DP_OFF : DP_OFF,
        ovf ? CODE_DASH :
        (blank_r && i > 0 && (bcd >> (4*i)) == '0) ? CODE_BLANK : {1'b0, bcd[4*i+:4]}};
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      digits <= {NDIGITS{DP_OFF, CODE_BLANK}};
      val <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      blank_r <= 1'b0;
      dp_r <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          val <= value;
          blank_r <= blank_en;
          dp_r <= dp_on;
          bcd <= '0;
          ovf <= 1'b0;
          cnt <= '0;
          busy <= 1'b1;
          state <= S_CONV;
        end
        S_CONV: begin
          {bcd, val} <= {adj, val} << 1;
          ovf <= ovf | adj[BW-1];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_FMT;
        end
        S_FMT: begin
          digits <= fmt;
          overflow <= ovf;
          done <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mfp_ahb_sevensegenc.sv
// tb_mfp_ahb_sevensegenc: directed self-checking bench for the seven-segment encoder
module tb_mfp_ahb_sevensegenc;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic [26:0] value = '0;
  logic blank_en = 1'b0;
  logic [7:0] dp_on = '0;
  logic busy, done, overflow;
  logic [47:0] digits;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mfp_ahb_sevensegenc dut (
    .clk(clk), .resetn(resetn), .start(start), .value(value), .blank_en(blank_en),
    .dp_on(dp_on), .busy(busy), .done(done), .overflow(overflow), .digits(digits)
  );
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // One conversion from idle: start sampled at edge 0, inputs scrambled after capture,
  // optional re-pulse of start (value 7) so that it is sampled at edge rp.
  task automatic conv(input string tag, input logic [26:0] v, input logic b, input logic [7:0] d,
                      input int rp, input logic [47:0] exp_d, input logic exp_o);
    int lat = -1;
    int nd = 0;
    logic busy1 = 1'b0;
    logic busy_end = 1'b1;
    value = v;
    blank_en = b;
    dp_on = d;
    start = 1'b1;
    for (int n = 0; n < 32; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n == 0) begin
        value = ~v;
        blank_en = ~b;
        dp_on = ~d;
      end
      if (n == rp - 1) begin
        value = 27'd7;
        start = 1'b1;
      end
      if (done) begin
        nd++;
        if (lat < 0) lat = n;
      end
      if (n == 1) busy1 = busy;
      if (n == 30) busy_end = busy;
    end
    check({tag, "_lat"}, 48'(lat), 48'd28);
    check({tag, "_ndone"}, 48'(nd), 48'd1);
    check({tag, "_busy"}, {47'd0, busy1}, 48'd1);
    check({tag, "_idle"}, {47'd0, busy_end}, 48'd0);
    check({tag, "_digits"}, digits, exp_d);
    check({tag, "_ovf"}, {47'd0, overflow}, {47'd0, exp_o});
  endtask
  initial begin
    logic saw_done;
    #12;
    check("rst_busy", {47'd0, busy}, 48'd0);
    check("rst_done", {47'd0, done}, 48'd0);
    check("rst_ovf", {47'd0, overflow}, 48'd0);
    check("rst_digits", digits, {8{6'h3F}});
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    conv("zero", 27'd0, 1'b1, 8'h00, -1, {{7{6'h3F}}, 6'h20}, 1'b0);
    conv("seq", 27'd12345678, 1'b0, 8'h00, -1,
         {6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h28}, 1'b0);
    conv("k1024", 27'd1024, 1'b1, 8'b00000100, -1,
         {{4{6'h3F}}, 6'h21, 6'h00, 6'h22, 6'h24}, 1'b0);
    conv("repulse", 27'd5, 1'b1, 8'h00, 10, {{7{6'h3F}}, 6'h25}, 1'b0);
    conv("seven", 27'd7, 1'b1, 8'h00, -1, {{7{6'h3F}}, 6'h27}, 1'b0);
    conv("max8", 27'd99999999, 1'b0, 8'h00, -1, {8{6'h29}}, 1'b0);
    conv("ovf1e8", 27'd100000000, 1'b0, 8'h00, -1, {8{6'h36}}, 1'b1);
    conv("ovfmax", 27'h7FFFFFF, 1'b1, 8'h00, -1, {8{6'h36}}, 1'b1);
    saw_done = 1'b0;
    value = 27'd99999999;
    blank_en = 1'b0;
    dp_on = 8'h00;
    start = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) saw_done = 1'b1;
    end
    resetn = 1'b0;
    #1;
    check("abort_busy", {47'd0, busy}, 48'd0);
    check("abort_done", {47'd0, done}, 48'd0);
    check("abort_ovf", {47'd0, overflow}, 48'd0);
    check("abort_digits", digits, {8{6'h3F}});
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    resetn = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_nodone", {47'd0, saw_done}, 48'd0);
    conv("after_rst", 27'd42, 1'b1, 8'h00, -1, {{6{6'h3F}}, 6'h24, 6'h22}, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mfp_ahb_sevensegenc.md
Name: mfp_ahb_sevensegenc

Overview:
Sequential binary-to-display-code encoder. It is the producer side of the 6-bit seven-segment digit code consumed by the segment decoder: bits [4:0] select the glyph, bit [5] is the active-low decimal point.
It converts an unsigned binary value into NDIGITS digit codes using iterative double-dabble. Optional leading-zero blanking, a per-digit decimal-point mask and an overflow dash pattern are supported.
It sits between the AHB display registers and the segment multiplexer.

Parameters:
WIDTH, 27, bit width of the binary input value (1..32).
NDIGITS, 8, number of decimal digits produced (1..8).

Ports:
clk  input  1  system clock, rising edge.
resetn  input  1  asynchronous active-low reset.
start  input  1  conversion request, sampled only in IDLE.
value  input  WIDTH  unsigned binary value, captured when start is accepted.
blank_en  input  1  1 = replace leading zeros with the blank code; captured at start.
dp_on  input  NDIGITS  1 = light the decimal point of digit i; captured at start.
busy  output  1  high from the edge after start is accepted until the edge that returns to IDLE.
done  output  1  one-cycle pulse; digits and overflow are valid and updated in this cycle.
overflow  output  1  value >= 10^NDIGITS in the last conversion; held until the next done.
digits  output  6*NDIGITS  digit i occupies bits [6i+5:6i]; digit 0 is rightmost. Registered and held between conversions.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, busy=0, done=0, overflow=0.
  - Every digit = 6'h3F (blank code 31, DP off). BCD register, shift counter and captured inputs are cleared.
  - Reset mid-conversion aborts it; no done pulse is produced.
- States: IDLE -> CONV -> FMT -> DONE -> IDLE.
- IDLE:
  - start=1 at an edge captures value, blank_en and dp_on; clears the BCD register (4*NDIGITS bits) and the sticky overflow flag; loads count=0; goes to CONV.
- CONV, one shift per edge, exactly WIDTH edges:
  - Each BCD nibble >= 5 gets +3.
  - Then {BCD, value} shifts left by 1.
  - The bit shifted out of the BCD MSB is ORed into the sticky overflow flag.
  - After count reaches WIDTH-1, go to FMT.
- FMT, one edge: load the digits register.
  - If overflow is set: every digit code = 22 (segment g only, dash).
  - Otherwise digit i code = BCD nibble i.
  - Blanking (blank_en=1): digit i (i>0) gets code 31 if it and all digits above it are 0. Digit 0 is never blanked.
  - Bit 5 of every digit = ~dp_on[i], including blanked and dash digits.
  - The overflow output is loaded at the same edge. Go to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: start sampled at edge 0; done is high in the cycle following edge WIDTH+1 (edge 28 with defaults). A new start is accepted no earlier than edge WIDTH+3.
- start while in CONV/FMT/DONE is ignored. No queuing, and the captured inputs are unaffected.
- Input changes after capture do not affect the conversion in progress.
- digits and overflow change only at the FMT->DONE edge or on reset.

Decomposition:
- Shared package (mfp_sevenseg_pkg):
  - CODE_BLANK=5'd31, CODE_DASH=5'd22, DP_OFF=1'b1.
  - Digit code width DIGIT_W=6 and glyph field width 5.
  - State encoding.
- Sub-module mfp_bcd_add3: combinational nibble correction (in >= 5 ? in+3 : in). It is instantiated NDIGITS times in a generate loop.
- Control FSM and datapath stay in the top module.

Test Plan:
1. value=0, blank_en=1, dp_on=0, start pulse -> done high 28 edges later. digits[7..1]=6'h3F, digit0=6'h20, overflow=0, busy low after DONE.
2. value=12345678, blank_en=0, dp_on=0 -> digit7..digit0 = 6'h21,22,23,24,25,26,27,28.
3. Boundary at 10^8:
   - value=99999999 -> all digits 6'h29, overflow=0.
   - Then value=100000000 -> all digits 6'h36, overflow=1.
   - Then value=134217727 (2^27-1) -> same dash pattern, overflow=1.
4. value=1024, blank_en=1, dp_on=8'b00000100 -> digit7..4=6'h3F, digit3=6'h21, digit2=6'h00, digit1=6'h22, digit0=6'h24.
5. Start handling:
   - start with value=5; re-pulse start with value=7 at edge 10 -> ignored, result digit0=6'h25, single done pulse.
   - start with value=7 after return to IDLE -> digit0=6'h27.
6. Reset and start after reset:
   - resetn low at edge 12 of a conversion -> busy, done and overflow drop immediately, all digits 6'h3F, no done pulse.
   - After release, start with value=42 -> digit1=6'h24, digit0=6'h22 with blank_en=1.
